sdr_cas_pipe: RTL and testbench
===============================

Name: sdr_cas_pipe

Overview:
- Parametrised CAS-latency read pipeline for the SDRAM controller read path.
- Takes read-command strobes from the command scheduler and tracks the programmed CAS latency (cfg_sdr_cas).
- Generates per-beat read-valid, last and tag strobes aligned with data on the SDRAM DQ bus, and captures that data.
- Supports run-time latency change with a drain handshake, configurable burst length, and read-interrupts-read truncation.

Parameters:
- MAX_CAS, 7: largest legal CAS latency; sets shift-register depth. Range 2..7.
- CAS_RST, 3: active latency loaded at reset.
- BURST_LEN, 4: beats per read burst. Range 1..8.
- DATA_W, 16: DQ width.
- TAG_W, 4: width of the command tag carried to the data beats.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- cfg_sdr_cas, in, 3: requested CAS latency; may change at any time.
- rd_cmd, in, 1: read command issued to SDRAM this cycle; accepted only when rd_cmd_rdy=1.
- rd_tag_in, in, TAG_W: tag of rd_cmd.
- rd_cmd_rdy, out, 1: block can accept rd_cmd.
- dq_in, in, DATA_W: SDRAM DQ sampled at clk.
- rd_valid, out, 1: rd_data holds a valid beat.
- rd_last, out, 1: final beat of a burst that was not truncated.
- rd_tag, out, TAG_W: tag of the current beat.
- rd_data, out, DATA_W: captured DQ.
- cas_act, out, 3: latency currently in force.
- cfg_busy, out, 1: a requested latency change is waiting for the pipe to drain.

Behaviour:
- Reset values: rd_valid=0, rd_last=0, rd_tag=0, rd_data=0, cas_act=CAS_RST, cfg_busy=0, rd_cmd_rdy=1. The shift register and burst counter are cleared.
- Reset mid-burst discards all in-flight commands. No beat appears after reset deasserts.
- Latency clamp: cas_req = cfg_sdr_cas, clamped as follows:
  - 0 or 1 becomes 2.
  - Any value above MAX_CAS becomes MAX_CAS.
- Timing:
  - An accepted rd_cmd at the cycle-t edge puts DQ beat 0 on the bus at edge t+cas_act.
  - dq_in is registered on that edge, so rd_valid/rd_data for beat 0 appear after edge t+cas_act+1, i.e. sampled high at edge t+cas_act+2.
  - Beats 1..BURST_LEN-1 follow on consecutive cycles.
- Shift register: a MAX_CAS-deep chain of {valid, tag}. A command is inserted at tap cas_act-1 so that it exits after cas_act cycles.
- Burst counter states: IDLE, BURST.
  - Exit event from the shift register: load counter=BURST_LEN-1, latch tag, go to BURST.
  - In BURST: count down each cycle. At 0 with no new exit event, return to IDLE.
  - rd_last is asserted on the beat where counter=0.
- Read-interrupts-read: an exit event during BURST reloads the counter and tag. The interrupted burst gets no rd_last. The new burst's beat 0 follows the old burst's last delivered beat with no gap.
- Latency-change handshake:
  - When cas_req≠cas_act, set cfg_busy=1 and rd_cmd_rdy=0.
  - When the shift register is empty, state is IDLE and cfg_busy=1: load cas_act=cas_req on the next edge, then drop cfg_busy and raise rd_cmd_rdy.
  - If cas_req returns to cas_act before the drain completes, clear cfg_busy without a load.
- rd_cmd while rd_cmd_rdy=0 is ignored: not inserted, no beats.
- rd_cmd coinciding with a change request in the same cycle is accepted under the old cas_act. rd_cmd_rdy falls on the following cycle.
- Back-to-back rd_cmd is legal every cycle; truncation rules apply.

Optional Feature:
- Macro: SDR_CAS_ERR_CHK_EN.
- Defined:
  - Adds output err_trunc (1-bit): a registered pulse the cycle a burst is truncated by a new exit event.
  - Adds output err_cfg (1-bit): sticky, set when cfg_sdr_cas is sampled outside 2..MAX_CAS; cleared only by reset.
- Undefined: both ports absent. Clamping and truncation behave identically, with no indication.

Test Plan:
- Reset, then one read at cas_act=3, BURST_LEN=4, tag=5, with dq_in=cycle count → rd_valid high 4 cycles starting 5 edges after the command edge; rd_last on beat 3; rd_tag=5; rd_data = DQ values of edges t+3..t+6.
- Commands at t and t+2, tags 1/2, BURST_LEN=4 → beats 1,1,2,2,2,2; rd_last only on the final beat; err_trunc pulses once with macro on.
- Change cfg 3→6 during an active burst → cfg_busy=1 and rd_cmd_rdy=0 until the burst ends; cas_act=6 one cycle after drain; next read shows 3 extra cycles of latency.
- cfg_sdr_cas=0, then 7 with MAX_CAS=5 → cas_act=2, then 5; err_cfg=1 and stays 1 with macro on.
- rd_cmd pulsed while rd_cmd_rdy=0 → no rd_valid ever appears for that tag.
- Assert reset mid-burst at beat 1 → all outputs return to reset values next edge; no further rd_valid.

Source files
------------

// File: rtl/sdr_cas_pipe_if.sv
// sdr_cas_pipe_if: read-path bus between the command scheduler / DQ pins and
// the CAS-latency read pipeline.
//   master : scheduler side; drives rd_cmd, rd_tag_in, dq_in; sees the beat strobes
//   slave  : pipeline side; drives rd_cmd_rdy and the per-beat outputs
interface sdr_cas_pipe_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
);
    logic              rd_cmd;
    logic [TAG_W-1:0]  rd_tag_in;
    logic              rd_cmd_rdy;
    logic [DATA_W-1:0] dq_in;
    logic              rd_valid;
    logic              rd_last;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output rd_cmd, rd_tag_in, dq_in,
        input  rd_cmd_rdy, rd_valid, rd_last, rd_tag, rd_data
    );

    modport slave (
        input  rd_cmd, rd_tag_in, dq_in,
        output rd_cmd_rdy, rd_valid, rd_last, rd_tag, rd_data
    );
endinterface

// File: rtl/sdr_cas_pipe.sv
// sdr_cas_pipe: CAS-latency read pipeline for the SDRAM controller read path.
// Tracks accepted read commands through a latency shift register, expands each
// exit into BURST_LEN beat strobes aligned with registered DQ data, and handles
// run-time latency changes by draining the pipe before loading the new value.
//
// Ports:
//   clk, reset   : clock (rising edge), synchronous active-high reset
//   bus (slave)  : rd_cmd/rd_tag_in/rd_cmd_rdy command side, dq_in capture,
//                  rd_valid/rd_last/rd_tag/rd_data beat outputs
//   cfg_sdr_cas  : requested CAS latency (clamped to 2..MAX_CAS)
//   cas_act      : latency currently in force
//   cfg_busy     : latency change waiting for the pipe to drain
// Optional (macro SDR_CAS_ERR_CHK_EN):
//   err_trunc    : one-cycle pulse when a burst is cut short by a newer read
//   err_cfg      : sticky flag, cfg_sdr_cas seen outside 2..MAX_CAS
module sdr_cas_pipe #(
    parameter int MAX_CAS   = 7,
    parameter int CAS_RST   = 3,
    parameter int BURST_LEN = 4,
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    sdr_cas_pipe_if.slave    bus,
    input  logic [2:0]       cfg_sdr_cas,
    output logic [2:0]       cas_act,
    output logic             cfg_busy
`ifdef SDR_CAS_ERR_CHK_EN
   ,output logic             err_trunc,
    output logic             err_cfg
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;
    localparam logic [2:0] MAX_C = 3'(MAX_CAS);
    localparam logic [2:0] CNT_LOAD = 3'(BURST_LEN - 1);

    logic [2:0]                    cas_req;
    logic                          rd_accept;
    logic [MAX_CAS-1:0]            sr_vld, sr_vld_nx;
    logic [MAX_CAS-1:0][TAG_W-1:0] sr_tag, sr_tag_nx;
    logic                          exit_ev;
    logic [0:0]                    state;
    logic [2:0]                    cnt;
    logic [TAG_W-1:0]              tag_q;
    logic [DATA_W-1:0]             dq_q;

    always_comb begin
        if (cfg_sdr_cas < 3'd2)
            cas_req = 3'd2;
        else if (cfg_sdr_cas > MAX_C)
            cas_req = MAX_C;
        else
            cas_req = cfg_sdr_cas;
    end

    assign bus.rd_cmd_rdy = ~cfg_busy;
    assign rd_accept      = bus.rd_cmd & ~cfg_busy;
    assign exit_ev        = sr_vld[0];

    // Shift toward tap 0 and insert at tap cas_act-1. That tap never holds a
    // shifted entry: inserts only happen at cas_act-1 and cas_act changes only
    // when the chain is empty.
    always_comb begin
        sr_vld_nx = sr_vld >> 1;
        sr_tag_nx = sr_tag >> TAG_W;
        for (int i = 0; i < MAX_CAS; i++) begin
            if (rd_accept && (i == int'(cas_act) - 1)) begin
                sr_vld_nx[i] = 1'b1;
                sr_tag_nx[i] = bus.rd_tag_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_vld       <= '0;
            sr_tag       <= '0;
            state        <= IDLE;
            cnt          <= '0;
            tag_q        <= '0;
            dq_q         <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_last  <= 1'b0;
            bus.rd_tag   <= '0;
            bus.rd_data  <= '0;
            cas_act      <= 3'(CAS_RST);
            cfg_busy     <= 1'b0;
        end else begin
            sr_vld <= sr_vld_nx;
            sr_tag <= sr_tag_nx;
            dq_q   <= bus.dq_in;

            // A new exit always restarts the counter, truncating any burst
            // still in progress; its beat 0 follows with no gap.
            if (exit_ev) begin
                state <= BURST;
                cnt   <= CNT_LOAD;
                tag_q <= sr_tag[0];
            end else if (state == BURST) begin
                if (cnt == 3'd0)
                    state <= IDLE;
                else
                    cnt <= cnt - 3'd1;
            end

            // Beat outputs lag the counter by one stage to line up with dq_q.
            bus.rd_valid <= (state == BURST);
            bus.rd_last  <= (state == BURST) && (cnt == 3'd0);
            if (state == BURST) begin
                bus.rd_tag  <= tag_q;
                bus.rd_data <= dq_q;
            end

            // Latency change: block new commands, wait for an empty pipe,
            // then load. A request that reverts before drain just cancels.
            if (cas_req != cas_act) begin
                if (cfg_busy && (sr_vld == '0) && (state == IDLE)) begin
                    cas_act  <= cas_req;
                    cfg_busy <= 1'b0;
                end else begin
                    cfg_busy <= 1'b1;
                end
            end else begin
                cfg_busy <= 1'b0;
            end
        end
    end

`ifdef SDR_CAS_ERR_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_trunc <= 1'b0;
            err_cfg   <= 1'b0;
        end else begin
            // An exit on the final beat (cnt==0) does not cut anything short.
            err_trunc <= exit_ev && (state == BURST) && (cnt != 3'd0);
            if ((cfg_sdr_cas < 3'd2) || (cfg_sdr_cas > MAX_C))
                err_cfg <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdr_cas_pipe.sv
module tb_sdr_cas_pipe;
    localparam int MAX_CAS = 6;
    localparam int CAS_RST = 3;
    localparam int BL      = 4;
    localparam int DW      = 16;
    localparam int TW      = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] cfg_sdr_cas;
    logic [2:0] cas_act;
    logic       cfg_busy;
`ifdef SDR_CAS_ERR_CHK_EN
    logic       err_trunc;
    logic       err_cfg;
    int         trunc_cnt = 0;
`endif

    sdr_cas_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    sdr_cas_pipe #(
        .MAX_CAS(MAX_CAS), .CAS_RST(CAS_RST), .BURST_LEN(BL),
        .DATA_W(DW), .TAG_W(TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .cfg_sdr_cas(cfg_sdr_cas),
        .cas_act(cas_act),
        .cfg_busy(cfg_busy)
`ifdef SDR_CAS_ERR_CHK_EN
       ,.err_trunc(err_trunc),
        .err_cfg(err_cfg)
`endif
    );

    always #5 clk = ~clk;

    // cyc counts rising edges; DQ carries the count, so beat data is predictable.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.dq_in = cyc[DW-1:0];

    typedef struct {
        logic [TW-1:0] tag;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    // Scoreboard keyed by the cycle (negedge sample) at which a beat is due.
    // A later read overwrites the tail of an earlier one, which is exactly
    // what truncation does to the visible beats.
    beat_t exp_q [int];

    int checks = 0;
    int errors = 0;
    int mcas   = CAS_RST;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.exists(cyc)) begin
                chk("rd_valid", int'(bus.rd_valid), 1);
                chk("rd_tag",   int'(bus.rd_tag),  int'(exp_q[cyc].tag));
                chk("rd_last",  int'(bus.rd_last), int'(exp_q[cyc].last));
                chk("rd_data",  int'(bus.rd_data), int'(exp_q[cyc].data));
                exp_q.delete(cyc);
            end else begin
                chk("rd_valid_idle", int'(bus.rd_valid), 0);
            end
`ifdef SDR_CAS_ERR_CHK_EN
            if (err_trunc) trunc_cnt++;
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drive one rd_cmd cycle; acc says whether the bench expects acceptance.
    task automatic issue(input logic [TW-1:0] tag, input bit acc);
        bus.rd_cmd    = 1'b1;
        bus.rd_tag_in = tag;
        chk("rd_cmd_rdy", int'(bus.rd_cmd_rdy), int'(acc));
        if (acc)
            for (int k = 0; k < BL; k++)
                exp_q[cyc + mcas + 2 + k] = '{tag: tag, last: (k == BL - 1),
                                              data: DW'(cyc + mcas + k)};
        tick();
        bus.rd_cmd = 1'b0;
    endtask

    task automatic chk_rst(input string pfx);
        chk({pfx, "_valid"}, int'(bus.rd_valid), 0);
        chk({pfx, "_last"},  int'(bus.rd_last), 0);
        chk({pfx, "_tag"},   int'(bus.rd_tag), 0);
        chk({pfx, "_data"},  int'(bus.rd_data), 0);
        chk({pfx, "_cas"},   int'(cas_act), CAS_RST);
        chk({pfx, "_busy"},  int'(cfg_busy), 0);
        chk({pfx, "_rdy"},   int'(bus.rd_cmd_rdy), 1);
    endtask

    typedef struct {
        logic [2:0] cfg;
        logic [2:0] cas;
    } vec_t;

    vec_t tbl [7];
    int   t0;

    initial begin
        tbl[0] = '{cfg: 3'd0, cas: 3'd2};
        tbl[1] = '{cfg: 3'd7, cas: 3'd6};
        tbl[2] = '{cfg: 3'd1, cas: 3'd2};
        tbl[3] = '{cfg: 3'd5, cas: 3'd5};
        tbl[4] = '{cfg: 3'd2, cas: 3'd2};
        tbl[5] = '{cfg: 3'd6, cas: 3'd6};
        tbl[6] = '{cfg: 3'd3, cas: 3'd3};

        reset         = 1'b1;
        cfg_sdr_cas   = 3'd3;
        bus.rd_cmd    = 1'b0;
        bus.rd_tag_in = '0;
        idle(3);
        chk_rst("rst");
        reset = 1'b0;
        tick();
        chk_rst("post_rst");
`ifdef SDR_CAS_ERR_CHK_EN
        chk("err_cfg_rst", int'(err_cfg), 0);
`endif

        // Single read, tag 5, CAS 3.
        issue(4'd5, 1'b1);
        idle(12);
        chk("single_drain", exp_q.size(), 0);

        // Reads two cycles apart: first burst truncated after two beats.
`ifdef SDR_CAS_ERR_CHK_EN
        trunc_cnt = 0;
`endif
        issue(4'd1, 1'b1);
        tick();
        issue(4'd2, 1'b1);
        idle(14);
        chk("trunc_drain", exp_q.size(), 0);
`ifdef SDR_CAS_ERR_CHK_EN
        chk("trunc_pulses", trunc_cnt, 1);
        trunc_cnt = 0;
`endif

        // Back-to-back reads every cycle.
        issue(4'd10, 1'b1);
        issue(4'd11, 1'b1);
        issue(4'd12, 1'b1);
        issue(4'd13, 1'b1);
        idle(14);
        chk("b2b_drain", exp_q.size(), 0);
`ifdef SDR_CAS_ERR_CHK_EN
        chk("b2b_pulses", trunc_cnt, 3);
`endif

        // Latency 3 -> 6 during a burst; a command while busy is dropped.
        t0 = cyc;
        issue(4'd7, 1'b1);
        cfg_sdr_cas = 3'd6;
        tick();
        for (int n = 2; n <= 9; n++) begin
            chk("chg_busy", int'(cfg_busy), (n <= 8) ? 1 : 0);
            chk("chg_cas",  int'(cas_act),  (n >= 9) ? 6 : 3);
            if (n == 4) issue(4'd9, 1'b0);
            else        tick();
        end
        mcas = 6;
        issue(4'd3, 1'b1);
        idle(16);
        chk("cas6_drain", exp_q.size(), 0);
        cfg_sdr_cas = 3'd3;
        idle(3);
        mcas = 3;
        chk("back_to_3", int'(cas_act), 3);

        // Change request that reverts before drain: cancel, no load.
        issue(4'd8, 1'b1);
        cfg_sdr_cas = 3'd5;
        idle(2);
        chk("revert_busy", int'(cfg_busy), 1);
        cfg_sdr_cas = 3'd3;
        tick();
        chk("revert_busy_clr", int'(cfg_busy), 0);
        chk("revert_cas", int'(cas_act), 3);
        chk("revert_rdy", int'(bus.rd_cmd_rdy), 1);
        idle(10);
        chk("revert_drain", exp_q.size(), 0);

        // Command coinciding with a change request uses the old latency.
        cfg_sdr_cas = 3'd5;
        issue(4'd10, 1'b1);
        chk("coin_rdy", int'(bus.rd_cmd_rdy), 0);
        idle(12);
        chk("coin_cas", int'(cas_act), 5);
        chk("coin_drain", exp_q.size(), 0);

        // Clamp table on an idle pipe.
        for (int i = 0; i < 7; i++) begin
            cfg_sdr_cas = tbl[i].cfg;
            idle(3);
            chk("clamp_cas", int'(cas_act), int'(tbl[i].cas));
            chk("clamp_busy", int'(cfg_busy), 0);
        end
        mcas = 3;
`ifdef SDR_CAS_ERR_CHK_EN
        chk("err_cfg_sticky", int'(err_cfg), 1);
`endif

        // Reset asserted while beat 1 of a burst is on the outputs.
        t0 = cyc;
        issue(4'd4, 1'b1);
        idle(5);
        chk("pre_rst_cyc", cyc, t0 + 6);
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk_rst("mid_rst");
        reset = 1'b0;
        idle(12);
`ifdef SDR_CAS_ERR_CHK_EN
        chk("err_cfg_clr", int'(err_cfg), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
